// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_if
// Brief    : EX-to-MEM handshake plus data-memory request/response bus.
// Revision : 1.0
// ============================================================================
interface mem_access_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           Instruction;
    logic [DATA_WIDTH-1:0] Result;
    logic [DATA_WIDTH-1:0] rt_data;
    logic [ADDR_WIDTH-1:0] Address;
    logic                  MemWrite;
    logic [DATA_WIDTH-1:0] Write_data;
    logic [3:0]            Write_strb;
    logic                  MemRead;
    logic                  Mem_Req_Ready;
    logic [DATA_WIDTH-1:0] Read_data;
    logic                  Read_data_Valid;
    logic                  Read_data_Ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        input  in_valid, Instruction, Result, rt_data,
        input  Mem_Req_Ready, Read_data, Read_data_Valid,
        output in_ready, Address, MemWrite, Write_data, Write_strb, MemRead,
        output Read_data_Ready, out_valid, out_data
    );

    modport slave (
        output in_valid, Instruction, Result, rt_data,
        output Mem_Req_Ready, Read_data, Read_data_Valid,
        input  in_ready, Address, MemWrite, Write_data, Write_strb, MemRead,
        input  Read_data_Ready, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Brief    : MIPS MEM stage; drives the data-memory handshake and formats
//            load results for write-back. Define MEM_UNALIGNED_EN to enable
//            lwl/lwr/swl/swr.
// Revision : 1.0
// ============================================================================
module mem_access #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic    clk,
    input  wire logic    rst,
    mem_access_if.master bus
);
    localparam logic [5:0] c_op_lb  = 6'b100000;
    localparam logic [5:0] c_op_lh  = 6'b100001;
    localparam logic [5:0] c_op_lwl = 6'b100010;
    localparam logic [5:0] c_op_lbu = 6'b100100;
    localparam logic [5:0] c_op_lhu = 6'b100101;
    localparam logic [5:0] c_op_lwr = 6'b100110;
    localparam logic [5:0] c_op_sb  = 6'b101000;
    localparam logic [5:0] c_op_sh  = 6'b101001;
    localparam logic [5:0] c_op_swl = 6'b101010;
    localparam logic [5:0] c_op_swr = 6'b101110;
    localparam logic [DATA_WIDTH-1:0] c_ones = '1;
`ifdef MEM_UNALIGNED_EN
    localparam logic c_unaligned_en = 1'b1;
`else
    localparam logic c_unaligned_en = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_REQ  = 3'd1,
        S_ST_REQ  = 3'd2,
        S_LD_WAIT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic                  r_rd_ready;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [5:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_ea;
    logic [DATA_WIDTH-1:0] r_rt;

    logic [5:0]            w_in_op;
    logic                  w_in_unaligned;
    logic                  w_in_load;
    logic                  w_in_store;
    logic [1:0]            w_a;
    logic [4:0]            w_sh_lo;
    logic [4:0]            w_sh_hi;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [3:0]            w_wstrb;
    logic                  w_unused;

    assign w_in_op        = bus.Instruction[31:26];
    assign w_unused       = ^bus.Instruction[25:0];
    assign w_in_unaligned = (w_in_op == c_op_lwl) || (w_in_op == c_op_lwr) ||
                            (w_in_op == c_op_swl) || (w_in_op == c_op_swr);
    // Without unaligned support those four opcodes fall through as non-memory.
    assign w_in_load      = (w_in_op[5:3] == 3'b100) && (c_unaligned_en || !w_in_unaligned);
    assign w_in_store     = (w_in_op[5:3] == 3'b101) && (c_unaligned_en || !w_in_unaligned);

    assign w_a     = r_ea[1:0];
    assign w_sh_lo = {w_a, 3'b000};
    assign w_sh_hi = {~w_a, 3'b000};
    assign w_half  = r_ea[1] ? bus.Read_data[31:16] : bus.Read_data[15:0];

    always_comb begin
        w_byte = bus.Read_data[7:0];
        case (w_a)
            2'd1:    w_byte = bus.Read_data[15:8];
            2'd2:    w_byte = bus.Read_data[23:16];
            2'd3:    w_byte = bus.Read_data[31:24];
            default: w_byte = bus.Read_data[7:0];
        endcase
    end

    always_comb begin
        w_load_data = bus.Read_data;
        case (r_op)
            c_op_lb:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_op_lbu: w_load_data = {24'd0, w_byte};
            c_op_lh:  w_load_data = {{16{w_half[15]}}, w_half};
            c_op_lhu: w_load_data = {16'd0, w_half};
`ifdef MEM_UNALIGNED_EN
            c_op_lwl: w_load_data = (bus.Read_data << w_sh_hi) | (r_rt & ~(c_ones << w_sh_hi));
            c_op_lwr: w_load_data = (bus.Read_data >> w_sh_lo) | (r_rt & ~(c_ones >> w_sh_lo));
`endif
            default:  w_load_data = bus.Read_data;
        endcase
    end

    // Narrow stores replicate the datum on every lane; strobes pick the lane.
    always_comb begin
        w_wdata = r_rt;
        w_wstrb = 4'b1111;
        case (r_op)
            c_op_sb: begin
                w_wdata = {4{r_rt[7:0]}};
                w_wstrb = 4'b0001 << w_a;
            end
            c_op_sh: begin
                w_wdata = {2{r_rt[15:0]}};
                w_wstrb = r_ea[1] ? 4'b1100 : 4'b0011;
            end
`ifdef MEM_UNALIGNED_EN
            c_op_swl: begin
                w_wdata = r_rt >> w_sh_hi;
                w_wstrb = 4'b1111 >> (~w_a);
            end
            c_op_swr: begin
                w_wdata = r_rt << w_sh_lo;
                w_wstrb = 4'b1111 << w_a;
            end
`endif
            default: begin
                w_wdata = r_rt;
                w_wstrb = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_rd_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_op        <= '0;
            r_ea        <= '0;
            r_rt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_op       <= w_in_op;
                        r_ea       <= bus.Result;
                        r_rt       <= bus.rt_data;
                        r_out_data <= bus.Result;
                        r_in_ready <= 1'b0;
                        if (w_in_load) begin
                            r_state    <= S_LD_REQ;
                            r_mem_read <= 1'b1;
                        end else if (w_in_store) begin
                            r_state     <= S_ST_REQ;
                            r_mem_write <= 1'b1;
                        end else begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_LD_REQ: begin
                    if (bus.Mem_Req_Ready) begin
                        r_state    <= S_LD_WAIT;
                        r_mem_read <= 1'b0;
                        r_rd_ready <= 1'b1;
                    end
                end
                S_ST_REQ: begin
                    if (bus.Mem_Req_Ready) begin
                        r_state     <= S_DONE;
                        r_mem_write <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                S_LD_WAIT: begin
                    if (bus.Read_data_Valid) begin
                        r_state     <= S_DONE;
                        r_rd_ready  <= 1'b0;
                        r_out_data  <= w_load_data;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_rd_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready        = r_in_ready;
    assign bus.MemRead         = r_mem_read;
    assign bus.MemWrite        = r_mem_write;
    assign bus.Read_data_Ready = r_rd_ready;
    assign bus.out_valid       = r_out_valid;
    assign bus.out_data        = r_out_data;
    assign bus.Address         = {r_ea[ADDR_WIDTH-1:2], 2'b00};
    assign bus.Write_data      = w_wdata;
    assign bus.Write_strb      = w_wstrb;
endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Brief    : Randomized scoreboard bench for mem_access with a byte-level
//            reference model; honours MEM_UNALIGNED_EN like the design.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mem_access;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    mem_access #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        is_read;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        int          req_d;
        int          rsp_d;
    } req_t;

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          acc_cyc;
    } exp_t;

    req_t req_q[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic abort_ok = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // kind: 0 = no memory access, 1 = load, 2 = store
    function automatic void predict(input logic [5:0] op, input logic [31:0] ea,
                                    input logic [31:0] rt, input logic [31:0] rd,
                                    output int kind, output logic [31:0] out,
                                    output logic [31:0] wdata, output logic [3:0] strb);
        logic [7:0] mb[4];
        logic [7:0] rb[4];
        logic [7:0] ob[4];
        int a;
        int h;
        a = int'(ea[1:0]);
        h = a / 2;
        for (int i = 0; i < 4; i++) begin
            mb[i] = rd[8*i +: 8];
            rb[i] = rt[8*i +: 8];
            ob[i] = 8'h00;
        end
        kind  = 0;
        out   = ea;
        wdata = 32'h0;
        strb  = 4'h0;
        case (op)
            6'h20: begin kind = 1; out = 32'($signed(mb[a])); end
            6'h24: begin kind = 1; out = {24'h0, mb[a]}; end
            6'h21: begin kind = 1; out = 32'($signed({mb[2*h+1], mb[2*h]})); end
            6'h25: begin kind = 1; out = {16'h0, mb[2*h+1], mb[2*h]}; end
            6'h23: begin kind = 1; out = rd; end
            6'h28: begin kind = 2; wdata = {4{rb[0]}}; strb[a] = 1'b1; end
            6'h29: begin kind = 2; wdata = {2{rb[1], rb[0]}}; strb[2*h] = 1'b1; strb[2*h+1] = 1'b1; end
            6'h2B: begin kind = 2; wdata = rt; strb = 4'hF; end
`ifdef MEM_UNALIGNED_EN
            6'h22: begin
                kind = 1;
                for (int i = 0; i < 4; i++)
                    if (i >= 3 - a) ob[i] = mb[i-(3-a)]; else ob[i] = rb[i];
                out = {ob[3], ob[2], ob[1], ob[0]};
            end
            6'h26: begin
                kind = 1;
                for (int i = 0; i < 4; i++)
                    if (i <= 3 - a) ob[i] = mb[i+a]; else ob[i] = rb[i];
                out = {ob[3], ob[2], ob[1], ob[0]};
            end
            6'h2A: begin
                kind = 2;
                for (int i = 0; i < 4; i++)
                    if (i <= a) begin ob[i] = rb[i+3-a]; strb[i] = 1'b1; end
                wdata = {ob[3], ob[2], ob[1], ob[0]};
            end
            6'h2E: begin
                kind = 2;
                for (int i = 0; i < 4; i++)
                    if (i >= a) begin ob[i] = rb[i-a]; strb[i] = 1'b1; end
                wdata = {ob[3], ob[2], ob[1], ob[0]};
            end
`endif
            default: kind = 0;
        endcase
    endfunction

    task automatic issue(input logic [5:0] op, input logic [31:0] ea, input logic [31:0] rt,
                         input logic [31:0] rd, input int req_d, input int rsp_d);
        int          kind;
        int          waitc;
        logic [31:0] out;
        logic [31:0] wd;
        logic [3:0]  sb;
        req_t        r;
        exp_t        e;
        predict(op, ea, rt, rd, kind, out, wd, sb);
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.Instruction = {op, 26'($urandom)};
        bus.Result      = ea;
        bus.rt_data     = rt;
        waitc = 0;
        while (!bus.in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 after %0d cycles", waitc);
            bus.in_valid = 1'b0;
            return;
        end
        e.data    = out;
        e.acc_cyc = cyc;
        e.lat     = (kind == 0) ? 1 : (kind == 2) ? 2 + req_d : 3 + req_d + rsp_d;
        exp_q.push_back(e);
        if (kind != 0) begin
            r.is_read = (kind == 1);
            r.addr    = {ea[31:2], 2'b00};
            r.wdata   = wd;
            r.strb    = sb;
            r.rdata   = rd;
            r.req_d   = req_d;
            r.rsp_d   = rsp_d;
            req_q.push_back(r);
        end
        @(negedge clk);
        bus.in_valid    = 1'b0;
        bus.Instruction = $urandom;
        bus.Result      = $urandom;
        bus.rt_data     = $urandom;
    endtask

    // Output monitor: pops the scoreboard whenever out_valid is seen.
    initial begin : monitor
        logic prev_ov;
        exp_t e;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.out_valid) begin
                chk("out_valid_pulse", {31'h0, prev_ov}, 32'h0);
                chk("in_ready_busy", {31'h0, bus.in_ready}, 32'h0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_unexpected: got out_valid with data %h expected none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", bus.out_data, e.data);
                    chk("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                end
            end
            prev_ov = bus.out_valid;
        end
    end

    // Memory model: grants after the per-request delay, answers loads, and
    // scatters ignorable Mem_Req_Ready / Read_data_Valid pulses elsewhere.
    initial begin : responder
        int          req_wait;
        int          rsp_wait;
        logic [31:0] rsp_data;
        req_t        cur;
        req_wait = -1;
        rsp_wait = -1;
        rsp_data = 32'h0;
        bus.Mem_Req_Ready   = 1'b0;
        bus.Read_data_Valid = 1'b0;
        bus.Read_data       = 32'h0;
        forever begin
            @(negedge clk);
            bus.Mem_Req_Ready   = 1'b0;
            bus.Read_data_Valid = 1'b0;
            bus.Read_data       = $urandom;
            if (bus.MemRead || bus.MemWrite) begin
                if (req_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL req_unexpected: got MemRead=%b MemWrite=%b expected none", bus.MemRead, bus.MemWrite);
                    bus.Mem_Req_Ready = 1'b1;
                end else begin
                    cur = req_q[0];
                    if (req_wait < 0) req_wait = cur.req_d;
                    chk("req_kind", {30'h0, bus.MemRead, bus.MemWrite}, {30'h0, cur.is_read, !cur.is_read});
                    chk("req_addr", bus.Address, cur.addr);
                    if (!cur.is_read) begin
                        chk("req_wdata", bus.Write_data, cur.wdata);
                        chk("req_wstrb", {28'h0, bus.Write_strb}, {28'h0, cur.strb});
                    end
                    if (cur.is_read && $urandom_range(0, 1) == 1) begin
                        bus.Read_data_Valid = 1'b1;
                        bus.Read_data       = ~cur.rdata;
                    end
                    if (req_wait == 0) begin
                        bus.Mem_Req_Ready = 1'b1;
                        void'(req_q.pop_front());
                        req_wait = -1;
                        if (cur.is_read) begin
                            rsp_wait = cur.rsp_d;
                            rsp_data = cur.rdata;
                        end
                    end else begin
                        req_wait--;
                    end
                end
            end else if (rsp_wait >= 0) begin
                if (abort_ok && !bus.Read_data_Ready) begin
                    rsp_wait = -1;
                end else begin
                    chk("rd_ready_wait", {31'h0, bus.Read_data_Ready}, 32'h1);
                    if (rsp_wait == 0) begin
                        bus.Read_data_Valid = 1'b1;
                        bus.Read_data       = rsp_data;
                        rsp_wait = -1;
                    end else begin
                        rsp_wait--;
                    end
                end
            end else begin
                bus.Mem_Req_Ready   = 1'($urandom_range(0, 1));
                bus.Read_data_Valid = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [5:0] ops [16];
        logic [5:0] op;
        int         waitc;
        ops = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h28,
                6'h29, 6'h2A, 6'h2B, 6'h2E, 6'h00, 6'h09, 6'h0D, 6'h0F};
        bus.in_valid    = 1'b0;
        bus.Instruction = 32'h0;
        bus.Result      = 32'h0;
        bus.rt_data     = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        chk("rst_memread", {31'h0, bus.MemRead}, 32'h0);
        chk("rst_memwrite", {31'h0, bus.MemWrite}, 32'h0);
        chk("rst_rd_ready", {31'h0, bus.Read_data_Ready}, 32'h0);
        chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("rst_out_data", bus.out_data, 32'h0);
        rst = 1'b0;

        issue(6'h00, 32'h0000_1234, 32'h5555_5555, 32'h0, 0, 0);
        issue(6'h20, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 0);
        issue(6'h24, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 0);
        issue(6'h29, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0, 3, 0);
        issue(6'h23, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 0, 5);
        issue(6'h22, 32'h0000_0001, 32'hDDCC_BBAA, 32'h4433_2211, 0, 0);

        // Reset while waiting for a load response.
        abort_ok = 1'b1;
        issue(6'h23, 32'h0000_0080, 32'h0, 32'h1357_9BDF, 0, 10);
        waitc = 0;
        while (!bus.Read_data_Ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk("reach_ld_wait", {31'h0, bus.Read_data_Ready}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_memread", {31'h0, bus.MemRead}, 32'h0);
        chk("midrst_rd_ready", {31'h0, bus.Read_data_Ready}, 32'h0);
        chk("midrst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("midrst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        exp_q.delete();
        req_q.delete();
        repeat (6) @(negedge clk);
        abort_ok = 1'b0;

        for (int t = 0; t < 250; t++) begin
            op = ops[$urandom_range(0, 15)];
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(op, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 4));
        end

        waitc = 0;
        while ((exp_q.size() != 0 || req_q.size() != 0) && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        chk("drain_pending", 32'(exp_q.size() + req_q.size()), 32'h0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
